// File: rtl/rpm_scan_controller.sv
// rtl/rpm_scan_controller.sv - round-robin tach period scanner sharing one counter; RPM_SCAN_SYNC_EN adds 2-flop input synchronizers
module rpm_scan_controller #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 1000000,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] tach,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CH_W-1:0]     res_chan,
  output logic [CNT_W-1:0]    res_period,
  output logic                res_stall,
  output logic                busy
);

  // Counter value on the last cycle before a channel is declared stalled
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    MEASURE,
    REPORT
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     chan;
  logic [CNT_W-1:0]    cnt;
  logic [CHANNELS-1:0] tach_s;
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] tach_edge;
  logic                chan_edge;
  logic [CH_W-1:0]     chan_next;

`ifdef RPM_SCAN_SYNC_EN
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  // Two-flop synchronizer for asynchronous tach pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= tach;
      sync2 <= sync1;
    end
  end

  assign tach_s = sync2;
`else
  assign tach_s = tach;
`endif

  // Previous sample of every tach bit, updated every cycle for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= tach_s;
    end
  end

  assign tach_edge = tach_s & ~prev;
  assign chan_edge = tach_edge[chan];
  assign chan_next = (chan == LAST_CH) ? '0 : chan + CH_W'(1);

  // Scan state machine: sync to the first edge, count to the second, report, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      chan       <= '0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_chan   <= '0;
      res_period <= '0;
      res_stall  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable) begin
            state <= SYNC;
            busy  <= 1'b1;
          end
        end

        SYNC: begin
          if (!enable) begin
            // Abandon the measurement; chan is kept so the same channel is retried
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (chan_edge) begin
            cnt   <= CNT_W'(1);
            state <= MEASURE;
          end else if (cnt == TMO_LAST) begin
            res_valid  <= 1'b1;
            res_chan   <= chan;
            res_period <= '0;
            res_stall  <= 1'b1;
            state      <= REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (chan_edge) begin
            // Edge has priority over a coincident timeout
            res_valid  <= 1'b1;
            res_chan   <= chan;
            res_period <= cnt;
            res_stall  <= 1'b0;
            state      <= REPORT;
          end else if (cnt == TMO_LAST) begin
            res_valid  <= 1'b1;
            res_chan   <= chan;
            res_period <= '0;
            res_stall  <= 1'b1;
            state      <= REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            chan      <= chan_next;
            cnt       <= '0;
            if (enable) begin
              state <= SYNC;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpm_scan_controller.sv
// tb/tb_rpm_scan_controller.sv - scoreboard bench for rpm_scan_controller
module tb_rpm_scan_controller;

  localparam int CHANNELS = 4;
  localparam int CNT_W    = 32;
  localparam int TIMEOUT  = 64;
  localparam int CH_W     = 2;
`ifdef RPM_SCAN_SYNC_EN
  localparam int EXP_LAT  = 3;
`else
  localparam int EXP_LAT  = 1;
`endif

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [CHANNELS-1:0] tach;
  logic                res_valid;
  logic                res_ready;
  logic [CH_W-1:0]     res_chan;
  logic [CNT_W-1:0]    res_period;
  logic                res_stall;
  logic                busy;

  rpm_scan_controller #(
    .CHANNELS(CHANNELS),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tach      (tach),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_chan  (res_chan),
    .res_period(res_period),
    .res_stall (res_stall),
    .busy      (busy)
  );

  typedef struct {
    int chan;
    int period;
    int stall;
    int gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_n = 0;
  int   last_hs = 0;

  int                  per[CHANNELS];
  int                  ph[CHANNELS];
  logic [CHANNELS-1:0] gen_t;
  logic [CHANNELS-1:0] man;
  logic [CHANNELS-1:0] man_t;

  assign tach = (gen_t & ~man) | (man_t & man);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int p, input int s, input int g);
    exp_t e;
    e.chan = c;
    e.period = p;
    e.stall = s;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(q.size() == 0), 64'd1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", 64'(hs_n >= target), 64'd1);
  endtask

  task automatic release_man(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (gen_t[i] && n < 50);
    man[i] = 1'b0;
  endtask

  // Square-wave generators: rising edge every per[i] cycles, per[i]==0 holds low
  initial begin
    for (int i = 0; i < CHANNELS; i++) begin
      ph[i] = 0;
      gen_t[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CHANNELS; i++) begin
        if (per[i] == 0) begin
          ph[i] = 0;
          gen_t[i] = 1'b0;
        end else begin
          ph[i] = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
          gen_t[i] = (ph[i] < per[i] / 2);
        end
      end
    end
  end

  // Monitor: a handshake occurs at the coming rising edge when valid & ready here
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && res_valid && res_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("res_chan", 64'(res_chan), 64'(e.chan));
          check("res_period", 64'(res_period), 64'(e.period));
          check("res_stall", 64'(res_stall), 64'(e.stall));
          if (e.gap != 0) check("stall_gap", 64'(cyc - last_hs), 64'(e.gap));
        end
        last_hs = cyc;
        hs_n++;
      end
    end
  end

  initial begin
    logic [35:0] snap;
    int          n;
    int          base;
    int          lat;

    rst_n = 1'b0;
    enable = 1'b0;
    res_ready = 1'b0;
    man = '0;
    man_t = '0;
    per[0] = 10;
    per[1] = 7;
    per[2] = 13;
    per[3] = 20;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_chan", 64'(res_chan), 64'd0);
    check("rst_period", 64'(res_period), 64'd0);
    check("rst_stall", 64'(res_stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Round-robin periods over two passes
    @(negedge clk);
    enable = 1'b1;
    res_ready = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < CHANNELS; c++) push(c, per[c], 0, 0);
    wait_empty(800);

    // Backpressure on the pending chan 0 result
    res_ready = 1'b0;
    per[1] = 0;
    man_t[2] = 1'b0;
    man[2] = 1'b1;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 64'(res_valid), 64'd1);
    snap = {res_valid, res_chan, res_stall, res_period};
    base = hs_n;
    repeat (20) begin
      @(negedge clk);
      check("bp_hold", 64'({res_valid, res_chan, res_stall, res_period}), 64'(snap));
    end
    check("bp_no_hs", 64'(hs_n), 64'(base));

    // Release: chan 0 accepted, chan 1 times out TIMEOUT cycles into SYNC
    push(0, 10, 0, 0);
    push(1, 0, 1, TIMEOUT + 1);
    res_ready = 1'b1;
    wait_hs(base + 2, 300);

    // Enable abort while chan 2 is in MEASURE
    @(negedge clk) man_t[2] = 1'b1;
    @(negedge clk) man_t[2] = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(res_valid), 64'd0);
    repeat (5) begin
      @(negedge clk);
      check("abort_idle", 64'({busy, res_valid}), 64'd0);
    end
    push(2, 13, 0, 0);
    push(3, 20, 0, 0);
    man_t[1] = 1'b0;
    man[1] = 1'b1;
    release_man(2);
    enable = 1'b1;
    wait_empty(400);
    push(0, 10, 0, 0);
    wait_empty(200);

    // Asynchronous reset during chan 1 MEASURE
    @(negedge clk) man_t[1] = 1'b1;
    @(negedge clk) man_t[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("meas_busy", 64'(busy), 64'd1);
    check("meas_no_valid", 64'(res_valid), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_chan", 64'(res_chan), 64'd0);
    check("arst_period", 64'(res_period), 64'd0);
    check("arst_stall", 64'(res_stall), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    per[1] = 2;
    man_t[2] = 1'b0;
    man[2] = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    push(0, 10, 0, 0);
    push(1, 2, 0, 0);
    release_man(1);
    wait_empty(400);

    // Minimum period with latency from the capturing pulse to res_valid
    man_t[2] = 1'b1;
    @(negedge clk) man_t[2] = 1'b0;
    @(negedge clk) man_t[2] = 1'b1;
    push(2, 2, 0, 0);
    push(3, 20, 0, 0);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) man_t[2] = 1'b0;
      lat++;
    end while (!res_valid && lat < 10);
    check("min_latency", 64'(lat), 64'(EXP_LAT));
    release_man(2);
    wait_empty(400);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
